// File: rtl/gpio_in_debounce.sv
// Debounced GPIO input port: per-bit 2-flop synchroniser and persistence filter,
// with a CPU register window for level, W1C change flags, interrupt mask and IRQ.
module gpio_in_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1200
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] gpio_i,
  input  logic             cs,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             irq_n
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_EDGE  = 2'd1,
    REG_MASK  = 2'd2,
    REG_RSVD  = 2'd3
  } reg_sel_e;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] accept;

  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] w1c;
  logic [7:0]       dout_q, dout_d;
  logic             irq_n_q, irq_n_d;

  reg_sel_e sel;
  logic     rd_en, wr_en;

  // Synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // A bit is accepted once s2 has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive clocks; any return to stable restarts the run.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Register window
  always_comb begin
    sel   = reg_sel_e'(addr);
    rd_en = cs & ~we;
    wr_en = cs & we;

    w1c    = (wr_en && sel == REG_EDGE) ? din[WIDTH-1:0] : '0;
    mask_d = (wr_en && sel == REG_MASK) ? din[WIDTH-1:0] : mask_q;
    // OR-ing accept after the clear makes a same-clock set win over W1C.
    edge_d = (edge_q & ~w1c) | accept;

    dout_d = dout_q;
    if (rd_en) begin
      unique case (sel)
        REG_LEVEL: dout_d = 8'(stable_q);
        REG_EDGE:  dout_d = 8'(edge_q);
        REG_MASK:  dout_d = 8'(mask_q);
        REG_RSVD:  dout_d = '0;
        default:   dout_d = '0;
      endcase
    end

    irq_n_d = ~|(edge_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q  <= '0;
      mask_q  <= '0;
      dout_q  <= '0;
      irq_n_q <= 1'b1;
    end else begin
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      dout_q  <= dout_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign gpio_i = stable_q;
  assign dout   = dout_q;
  assign irq_n  = irq_n_q;

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-side GPIO port for the 6502 test system: the counterpart of the LED output path. It takes up to 8 raw board pins (buttons/switches), synchronises and debounces each bit independently, and presents the clean levels on `gpio_i` for the CPU. It also exposes a small CPU register window with per-bit change flags and an interrupt request. It sits in the board top between the pins and `tst_6502`, clocked by the divided 12 MHz system clock.

## Interface
- `WIDTH`, 8: number of input bits, 1..8.
- `DEBOUNCE_CYCLES`, 1200: consecutive clocks a new level must persist before it is accepted (100 µs at 12 MHz); minimum 2.
- `clk`  in  1  system clock (12 MHz domain).
- `reset_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `pin_i`  in  WIDTH  raw asynchronous board inputs.
- `gpio_i`  out  WIDTH  debounced levels, fed to the CPU GPIO input.
- `cs`  in  1  register access strobe, one clock per access.
- `we`  in  1  1 = write, 0 = read; sampled with `cs`.
- `addr`  in  2  register select.
- `din`  in  8  write data.
- `dout`  out  8  read data, registered.
- `irq_n`  out  1  active-low interrupt, registered.

## Operation
- Per bit, a 2-flop synchroniser `pin_i` -> `s1` -> `s2`, then the debouncer state `stable` (drives `gpio_i`) and counter `cnt` (width `$clog2(DEBOUNCE_CYCLES)`).
- Debounce, each clock, per bit:
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, set `edge[bit]`.
  - Otherwise: `cnt <= cnt+1`.
  - Any glitch back to `stable` restarts the count from 0.
- Both rising and falling accepted transitions set `edge[bit]`.
- Registers, with unused upper bits reading 0:
  - addr 0: `gpio_i` level, read-only; writes are ignored.
  - addr 1: `edge` flags. Reading returns them. Writing 1 to a bit clears it (W1C); writing 0 leaves it unchanged.
  - addr 2: `mask`, read/write. Bits at WIDTH and above are not stored.
  - addr 3: reads 0; writes are ignored.
- Simultaneous W1C clear and a new accepted transition on the same bit in the same clock: the set wins and the flag stays 1.
- `irq_n <= ~|(edge & mask)`.
- Reset values: `s1`, `s2`, `stable`, `gpio_i` = 0; `cnt` = 0; `edge` = 0; `mask` = 0; `dout` = 0; `irq_n` = 1.
- Reset asserted mid-debounce aborts the count. After release, a pin held high is accepted afresh and sets its edge flag.

## Timing
- Pin-to-`gpio_i` latency: `DEBOUNCE_CYCLES+2` rising edges, counting the first edge that samples the new level into `s1`.
- `edge[bit]` is set on the same edge that `stable` changes.
- `irq_n` falls one clock after that, provided the mask bit is set.
- Read: `cs=1,we=0` at edge N; `dout` is valid after edge N and holds until the next read.
- Write: takes effect at edge N. The effect of a write on `irq_n` is visible after edge N+1.
- Setting a mask bit while its edge flag is already 1 asserts `irq_n` one clock after the write.
- A pulse shorter than `DEBOUNCE_CYCLES` clocks at `s2` never changes `gpio_i` and never sets a flag.
- Independent bits may be accepted in the same clock; flags are set together.

## Test plan
Parameters: `DEBOUNCE_CYCLES=4`, `WIDTH=8`.
- Reset: hold `reset_n=0`, `pin_i=8'hFF`, then release -> `gpio_i=8'h00`, `irq_n=1`, `dout=0` throughout reset. After release, `gpio_i` becomes `8'hFF` exactly 6 edges after the first sampling edge.
- Glitch rejection: `pin_i[0]` high for 3 clocks then low -> `gpio_i` stays `8'h00` and the addr 1 read returns `8'h00`. A 4-clock pulse reaching `s2` -> `gpio_i[0]` goes high, and the flag reads `8'h01`.
- Interrupt flow: write `mask=8'h04`, raise `pin_i[2]` -> `irq_n=0` one clock after `gpio_i[2]` rises. Writing `8'h04` to addr 1 brings `irq_n` back to 1 two edges after the write. Raising an unmasked bit 3 leaves `irq_n=1`, but addr 1 reads `8'h08`.
- Set vs clear collision: time the W1C of bit 5 to the edge where bit 5's falling transition is accepted -> addr 1 still reads bit 5 = 1.
- Register map: write `8'hAA` to addr 0 and to addr 3 -> no change. Addr 2 written `8'hFF` reads `8'hFF`. Addr 3 reads `8'h00`.
- Async reset mid-count: assert `reset_n` at a non-edge time while `cnt=2` -> all outputs take their reset values immediately, without waiting for a clock edge.
